// File: rtl/rtc_pkg.sv
// rtc_pkg: shared ASCII codes, UART state encoding and BCD time layout for the RTC time-set path
package rtc_pkg;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_9 = 8'h39;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  typedef struct packed {
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [2:0] sec1;
    logic [3:0] sec0;
  } bcd_time_t;
  // Tens digits arrive as full 4-bit values so out-of-range digits are rejected before narrowing.
  function automatic logic time_ok(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] s1);
    return h1 <= 4'd2 && !(h1 == 4'd2 && h0 > 4'd3) && m1 <= 4'd5 && s1 <= 4'd5;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 16x oversampling, start-glitch rejection and stop-bit check
// clk, rst (async active-low), rxd (raw line) -> rx_data, byte_valid (1-clk), frame_err (1-clk), busy
module uart_rx_byte
  import rtc_pkg::*;
#(
  parameter int div16x = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(div16x);
  logic [1:0] sync;
  logic rxd_s;
  logic rxd_d;
  logic tick;
  logic [CW-1:0] cnt;
  logic [3:0] phase;
  logic [2:0] bitn;
  uart_state_t st;
  assign rxd_s = sync[1];
  assign tick = cnt == CW'(div16x - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= 2'b11;
      rxd_d <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], rxd};
      rxd_d <= rxd_s;
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      phase <= '0;
      bitn <= '0;
      rx_data <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      case (st)
        IDLE:
          if (rxd_d && !rxd_s) begin
            phase <= '0;
            busy <= 1'b1;
            st <= START;
          end
        START:
          if (tick) begin
            phase <= phase + 4'd1;
            // A line that is high again at mid-start was only a glitch.
            if (phase == 4'd7) begin
              phase <= '0;
              bitn <= '0;
              busy <= !rxd_s;
              st <= rxd_s ? IDLE : DATA;
            end
          end
        DATA:
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              rx_data <= {rxd_s, rx_data[7:1]};
              bitn <= bitn + 3'd1;
              if (bitn == 3'd7) st <= STOP;
            end
          end
        STOP:
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              busy <= 1'b0;
              byte_valid <= rxd_s;
              frame_err <= !rxd_s;
              st <= IDLE;
            end
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: rtl/rtc_serial_set.sv
// rtc_serial_set: parses "HHMMSS<CR>" from a UART line into range-checked BCD time with a load strobe
// clk, rst (async active-low), rxd -> load, hr1/hr0/min1/min0/sec1/sec0, frame_err, fmt_err, busy
module rtc_serial_set
  import rtc_pkg::*;
#(
  parameter int div16x = 27,
  parameter bit lf_ignore = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       load,
  output logic [1:0] hr1,
  output logic [3:0] hr0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic [2:0] sec1,
  output logic [3:0] sec0,
  output logic       frame_err,
  output logic       fmt_err,
  output logic       busy
);
  logic [7:0] rx_data;
  logic byte_valid;
  logic is_dig;
  logic ok;
  logic commit;
  logic [2:0] idx;
  logic [3:0] stg [6];
  bcd_time_t tm;
  uart_rx_byte #(.div16x(div16x)) u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_data(rx_data),
    .byte_valid(byte_valid),
    .frame_err(frame_err),
    .busy(busy)
  );
  always_comb begin
    is_dig = rx_data >= ASC_0 && rx_data <= ASC_9;
    ok = time_ok(stg[0], stg[1], stg[2], stg[4]);
  end
  assign {hr1, hr0, min1, min0, sec1, sec0} = tm;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      stg <= '{default: '0};
      commit <= 1'b0;
      load <= 1'b0;
      fmt_err <= 1'b0;
      tm <= '0;
    end else begin
      fmt_err <= 1'b0;
      commit <= 1'b0;
      load <= commit;
      // Staging cannot change between commit and copy: the next byte is a full frame away.
      if (commit) tm <= {stg[0][1:0], stg[1], stg[2][2:0], stg[3], stg[4][2:0], stg[5]};
      if (frame_err) idx <= '0;
      else if (byte_valid) begin
        if (is_dig && idx < 3'd6) begin
          stg[idx] <= rx_data[3:0];
          idx <= idx + 3'd1;
        end else if (rx_data == ASC_CR && idx == 3'd6 && ok) begin
          commit <= 1'b1;
          idx <= '0;
        end else if (!(lf_ignore && rx_data == ASC_LF)) begin
          fmt_err <= 1'b1;
          idx <= '0;
        end
      end
    end
endmodule

// File: tb/tb_rtc_serial_set.sv
// tb_rtc_serial_set: directed frames over the serial line with hand-computed time fields and pulse counts
module tb_rtc_serial_set;
  localparam int DIV = 3;
  localparam int BIT = 16 * DIV;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic load, frame_err, fmt_err, busy;
  logic [1:0] hr1;
  logic [3:0] hr0, min0, sec0;
  logic [2:0] min1, sec1;
  logic [19:0] f;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, load_lat = -1;
  int n_load = 0, n_fmt = 0, n_ferr = 0, n_excl = 0;
  int l0, e0, r0;
  logic busy_q = 1'b0;

  rtc_serial_set #(.div16x(DIV), .lf_ignore(1'b1)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .load(load),
    .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .frame_err(frame_err), .fmt_err(fmt_err), .busy(busy)
  );

  always #10 clk = ~clk;
  assign f = {hr1, hr0, min1, min0, sec1, sec0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    busy_q <= busy;
    if (busy_q && !busy) fall_cyc <= cyc;
    if (load) begin
      n_load <= n_load + 1;
      load_lat <= cyc - fall_cyc;
    end
    if (fmt_err) n_fmt <= n_fmt + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (int'(load) + int'(fmt_err) + int'(frame_err) > 1) n_excl <= n_excl + 1;
  end

  function automatic logic [19:0] t(input int h1, input int h0, input int m1, input int m0, input int s1, input int s0);
    return {h1[1:0], h0[3:0], m1[2:0], m0[3:0], s1[2:0], s0[3:0]};
  endfunction

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    idle(BIT);
  endtask

  task automatic snap();
    l0 = n_load;
    e0 = n_fmt;
    r0 = n_ferr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_chk++; if (f !== 20'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", f); end
    n_chk++; if ({load, fmt_err, frame_err, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {load, fmt_err, frame_err, busy}); end
    rst = 1'b1;
    idle(BIT);
  endtask

  task automatic test_basic();
    snap();
    send_str("123456\015");
    n_chk++; if (n_load - l0 != 1) begin n_fail++; $display("FAIL basic_load_count: got %0d want 1", n_load - l0); end
    n_chk++; if (load_lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", load_lat); end
    n_chk++; if (f !== t(1, 2, 3, 4, 5, 6)) begin n_fail++; $display("FAIL basic_fields: got %h want %h", f, t(1, 2, 3, 4, 5, 6)); end
    n_chk++; if (n_fmt - e0 != 0 || n_ferr - r0 != 0) begin n_fail++; $display("FAIL basic_errs: got fmt %0d ferr %0d want 0 0", n_fmt - e0, n_ferr - r0); end
  endtask

  task automatic test_range();
    snap();
    send_str("235959\015");
    n_chk++; if (n_load - l0 != 1) begin n_fail++; $display("FAIL range_max_load: got %0d want 1", n_load - l0); end
    n_chk++; if (f !== t(2, 3, 5, 9, 5, 9)) begin n_fail++; $display("FAIL range_max_fields: got %h want %h", f, t(2, 3, 5, 9, 5, 9)); end
    snap();
    send_str("240000\015");
    n_chk++; if (n_fmt - e0 != 1 || n_load != l0) begin n_fail++; $display("FAIL range_hour24: got fmt %0d load %0d want 1 0", n_fmt - e0, n_load - l0); end
    snap();
    send_str("206000\015");
    n_chk++; if (n_fmt - e0 != 1 || n_load != l0) begin n_fail++; $display("FAIL range_min60: got fmt %0d load %0d want 1 0", n_fmt - e0, n_load - l0); end
    snap();
    send_str("300000\015");
    n_chk++; if (n_fmt - e0 != 1 || n_load != l0) begin n_fail++; $display("FAIL range_hr1_3: got fmt %0d load %0d want 1 0", n_fmt - e0, n_load - l0); end
    n_chk++; if (f !== t(2, 3, 5, 9, 5, 9)) begin n_fail++; $display("FAIL range_hold: got %h want %h", f, t(2, 3, 5, 9, 5, 9)); end
  endtask

  task automatic test_format();
    snap();
    send_str("1234\015");
    n_chk++; if (n_fmt - e0 != 1) begin n_fail++; $display("FAIL fmt_short: got %0d want 1", n_fmt - e0); end
    snap();
    send_str("12a456\015");
    n_chk++; if (n_fmt - e0 != 2) begin n_fail++; $display("FAIL fmt_alpha: got %0d want 2", n_fmt - e0); end
    snap();
    send_str("1234567\015");
    n_chk++; if (n_fmt - e0 != 2) begin n_fail++; $display("FAIL fmt_long: got %0d want 2", n_fmt - e0); end
    n_chk++; if (n_load != l0 || f !== t(2, 3, 5, 9, 5, 9)) begin n_fail++; $display("FAIL fmt_hold: got load %0d fields %h want 0 %h", n_load - l0, f, t(2, 3, 5, 9, 5, 9)); end
  endtask

  task automatic test_frame_err();
    snap();
    send_byte("1");
    send_byte("2");
    send_byte("X", 1'b0);
    idle(BIT);
    n_chk++; if (n_ferr - r0 != 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", n_ferr - r0); end
    send_str("456\015");
    n_chk++; if (n_fmt - e0 != 1 || n_load != l0) begin n_fail++; $display("FAIL ferr_restart: got fmt %0d load %0d want 1 0", n_fmt - e0, n_load - l0); end
  endtask

  task automatic test_lf();
    snap();
    send_str("08\0123000\015");
    n_chk++; if (n_load - l0 != 1 || n_fmt != e0) begin n_fail++; $display("FAIL lf_pulses: got load %0d fmt %0d want 1 0", n_load - l0, n_fmt - e0); end
    n_chk++; if (f !== t(0, 8, 3, 0, 0, 0)) begin n_fail++; $display("FAIL lf_fields: got %h want %h", f, t(0, 8, 3, 0, 0, 0)); end
  endtask

  task automatic test_glitch();
    snap();
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * BIT);
    n_chk++; if (busy !== 1'b0 || n_ferr != r0 || n_fmt != e0 || n_load != l0) begin n_fail++; $display("FAIL glitch: got busy %b ferr %0d fmt %0d load %0d want 0 0 0 0", busy, n_ferr - r0, n_fmt - e0, n_load - l0); end
  endtask

  task automatic test_break();
    snap();
    @(negedge clk);
    rxd = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    #1;
    n_chk++; if (n_ferr - r0 != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL break: got ferr %0d busy %b want 1 0", n_ferr - r0, busy); end
    idle(2 * BIT);
    n_chk++; if (n_ferr - r0 != 1 || n_fmt != e0) begin n_fail++; $display("FAIL break_release: got ferr %0d fmt %0d want 1 0", n_ferr - r0, n_fmt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = "0";
    send_byte("0");
    send_byte("0");
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (f !== 20'd0) begin n_fail++; $display("FAIL midrst_fields: got %h want 0", f); end
    n_chk++; if ({load, fmt_err, frame_err, busy} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %b want 0000", {load, fmt_err, frame_err, busy}); end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    rst = 1'b1;
    idle(3 * BIT);
    n_chk++; if (n_load != l0 || n_fmt != e0 || n_ferr != r0) begin n_fail++; $display("FAIL midrst_spurious: got load %0d fmt %0d ferr %0d want 0 0 0", n_load - l0, n_fmt - e0, n_ferr - r0); end
    send_str("000001\015");
    n_chk++; if (n_load - l0 != 1 || n_fmt != e0 || n_ferr != r0) begin n_fail++; $display("FAIL midrst_reload: got load %0d fmt %0d ferr %0d want 1 0 0", n_load - l0, n_fmt - e0, n_ferr - r0); end
    n_chk++; if (f !== t(0, 0, 0, 0, 0, 1)) begin n_fail++; $display("FAIL midrst_value: got %h want %h", f, t(0, 0, 0, 0, 0, 1)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_format();
    test_frame_err();
    test_lf();
    test_glitch();
    test_break();
    test_reset_mid();
    n_chk++; if (n_excl != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_excl); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
